ps2_cmd_sched: RTL

Host-side command scheduler for the PS/2 keyboard path.
- Accepts command bytes from the host (e.g. 0xED LED set, 0xF4 enable, 0xFF reset) and sequences them onto the keyboard transmit shifter.
- Arbitrates the shared PS/2 line so that no transmission starts while a receive frame is in progress.
- Waits for the keyboard ACK (0xFA), retries on RESEND (0xFE) and enforces an ACK timeout.
- Buffers all other received scancodes in a small FIFO for the host.

---
 rtl/ps2_cmd_sched.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/ps2_cmd_sched.sv
// ps2_cmd_sched: host-side command scheduler for the PS/2 keyboard path.
//
// Takes a command byte from the host and sends it to the keyboard transmit
// shifter. A frame is started only while the receive side is quiet. The block
// then waits for the keyboard ACK (0xFA), retransmits on RESEND (0xFE), and
// gives up after ACK_TIMEOUT cycles. Every other received byte goes into a
// show-ahead scancode FIFO for the host.
//
// Handshake rule for cmd_valid/cmd_ready: a command byte moves on a rising
// clock edge where cmd_valid and cmd_ready are both high. cmd_ready does not
// depend on cmd_valid. The host must hold cmd_byte stable while it holds
// cmd_valid.
//
// Optional feature macro: PS2_CMD_ACK_PASSTHRU_EN. When it is defined, an
// ACK or RESEND byte that the command engine consumes is also copied into
// the FIFO.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   cmd_valid/ready   host command handshake; cmd_byte carries the command
//   cmd_done          one-cycle completion pulse, qualifies cmd_status
//   cmd_status        00 ok, 01 retries exhausted, 10 ACK timeout, 11 tx error
//   rx_strobe/byte    received byte from the receive shifter
//   rx_busy           receive shifter is mid-frame
//   tx_start/byte     start pulse and data for the transmit shifter
//   tx_done/error     line-level result of a transmit frame
//   key_valid/byte    FIFO not empty / FIFO head (show-ahead)
//   key_pop           pop the FIFO head (ignored when empty)
//   fifo_overflow     sticky, set when a byte is dropped because the FIFO is full
module ps2_cmd_sched #(
  parameter int ACK_TIMEOUT    = 640000,
  parameter int ACK_TIMER_BITS = 20,
  parameter int MAX_RETRY      = 3,
  parameter int FIFO_AW        = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_byte,
  output logic       cmd_ready,
  output logic       cmd_done,
  output logic [1:0] cmd_status,
  input  logic       rx_strobe,
  input  logic [7:0] rx_byte,
  input  logic       rx_busy,
  output logic       tx_start,
  output logic [7:0] tx_byte,
  input  logic       tx_done,
  input  logic       tx_error,
  output logic       key_valid,
  output logic [7:0] key_byte,
  input  logic       key_pop,
  output logic       fifo_overflow
);

  localparam int DEPTH      = 1 << FIFO_AW;
  localparam int RETRY_BITS = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [ACK_TIMER_BITS-1:0] TIMER_LAST = ACK_TIMER_BITS'(ACK_TIMEOUT - 1);
  localparam logic [RETRY_BITS-1:0]     RETRY_MAX  = RETRY_BITS'(MAX_RETRY);
  localparam logic [FIFO_AW:0]          FIFO_FULL  = (FIFO_AW + 1)'(DEPTH);
  localparam logic [7:0] BYTE_ACK    = 8'hFA;
  localparam logic [7:0] BYTE_RESEND = 8'hFE;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_ARB      = 3'd1;
  localparam logic [2:0] ST_SEND     = 3'd2;
  localparam logic [2:0] ST_WAIT_TX  = 3'd3;
  localparam logic [2:0] ST_WAIT_ACK = 3'd4;
  localparam logic [2:0] ST_DONE     = 3'd5;

  logic [2:0]                state;
  logic [ACK_TIMER_BITS-1:0] ack_timer;
  logic [RETRY_BITS-1:0]     retry_cnt;
  logic [1:0]                status_q;
  logic [7:0]                tx_byte_q;

  logic is_ack, is_resend;
  assign is_ack    = rx_strobe && (rx_byte == BYTE_ACK);
  assign is_resend = rx_strobe && (rx_byte == BYTE_RESEND);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      ack_timer <= '0;
      retry_cnt <= '0;
      status_q  <= 2'b00;
      tx_byte_q <= 8'h00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            tx_byte_q <= cmd_byte;
            retry_cnt <= '0;
            state     <= ST_ARB;
          end
        end
        // Start only when the receive side is idle and no byte is arriving
        // in this same cycle.
        ST_ARB: begin
          if (!rx_busy && !rx_strobe) state <= ST_SEND;
        end
        ST_SEND: state <= ST_WAIT_TX;
        ST_WAIT_TX: begin
          if (tx_error) begin
            status_q <= 2'b11;
            state    <= ST_DONE;
          end else if (tx_done) begin
            ack_timer <= '0;
            state     <= ST_WAIT_ACK;
          end
        end
        ST_WAIT_ACK: begin
          ack_timer <= ack_timer + 1'b1;
          // A response byte is checked before the timeout. If one arrives on
          // the last timer cycle, it still counts as the keyboard's answer.
          if (is_ack) begin
            status_q <= 2'b00;
            state    <= ST_DONE;
          end else if (is_resend) begin
            if (retry_cnt < RETRY_MAX) begin
              retry_cnt <= retry_cnt + 1'b1;
              state     <= ST_ARB;
            end else begin
              status_q <= 2'b01;
              state    <= ST_DONE;
            end
          end else if (ack_timer == TIMER_LAST) begin
            status_q <= 2'b10;
            state    <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // The pulses are gated by reset so that a reset landing in SEND or DONE
  // produces no start pulse and no completion pulse.
  assign cmd_ready  = (state == ST_IDLE);
  assign cmd_done   = (state == ST_DONE) && !reset;
  assign cmd_status = status_q;
  assign tx_start   = (state == ST_SEND) && !reset;
  assign tx_byte    = tx_byte_q;

  // Scancode FIFO
  logic [7:0]         mem [0:DEPTH-1];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               push_req, push_ok, pop, full;

`ifdef PS2_CMD_ACK_PASSTHRU_EN
  assign push_req = rx_strobe;
`else
  logic consumed;
  assign consumed = (state == ST_WAIT_ACK) && (is_ack || is_resend);
  assign push_req = rx_strobe && !consumed;
`endif

  assign full    = (count == FIFO_FULL);
  assign pop     = key_pop && (count != '0);
  // When the FIFO is full, a pop in the same cycle frees the slot for the push.
  assign push_ok = push_req && (!full || pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      fifo_overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_req && full && !pop) fifo_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= rx_byte;
  end

  assign key_valid = (count != '0);
  assign key_byte  = key_valid ? mem[rd_ptr] : 8'h00;

endmodule
